// File: rtl/fp_pkg.sv
// Shared single-precision field constants and accumulator FSM states.
// The converter and the later FP stages import this package as well.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
    localparam logic [31:0]      FP_ZERO = 32'h0000_0000;
    localparam logic [31:0]      FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;
endpackage

// File: rtl/fp_align_shift.sv
// Significand alignment shifter: truncating right shift, zero once every
// bit of the 24-bit significand would be shifted out.
module fp_align_shift (
    input  logic [23:0] sig_i,
    input  logic [7:0]  shamt_i,
    output logic [23:0] sig_o
);
    // Shift amounts of 24 or more leave nothing of the significand.
    always_comb begin
        sig_o = 24'd0;
        if (shamt_i < 8'd24) sig_o = sig_i >> shamt_i;
    end
endmodule

// File: rtl/fp_accumulator.sv
// Sums N_SAMPLES non-negative singles with an ALIGN/ADD/NORM sequence per
// operand, then holds the result until the downstream stage takes it.
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        sum_valid,
    input  logic        sum_ready,
    output logic [31:0] sum_data,
    output logic        overflow
);
    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d, opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    // Pipeline-stage scratch registers carried between ALIGN, ADD and NORM.
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [23:0]      big_q, big_d, sml_q, sml_d;
    logic [24:0]      sum_q, sum_d;
    logic             inf_q, inf_d, zero_q, zero_d;

    logic [EXP_W-1:0] ea, eb, shamt, n_exp;
    logic [23:0]      sa, sb, sh_in, sh_out;
    logic [MAN_W-1:0] n_man;
    logic             acc_big;

    // Operand decode: exponent 0 flushes to zero regardless of mantissa.
    always_comb begin
        ea      = acc_q[30:23];
        eb      = opb_q[30:23];
        sa      = (ea == '0) ? 24'd0 : {1'b1, acc_q[22:0]};
        sb      = (eb == '0) ? 24'd0 : {1'b1, opb_q[22:0]};
        acc_big = (ea >= eb);
        shamt   = acc_big ? (ea - eb) : (eb - ea);
        sh_in   = acc_big ? sb : sa;
    end

    fp_align_shift u_shift (
        .sig_i   (sh_in),
        .shamt_i (shamt),
        .sig_o   (sh_out)
    );

    // Post-add normalization: a carry into bit 24 costs one truncating shift.
    always_comb begin
        n_exp = exp_q;
        n_man = sum_q[22:0];
        if (sum_q[24]) begin
            n_exp = exp_q + 8'd1;
            n_man = sum_q[23:1];
        end
    end

    // FSM next state and datapath next values.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        exp_d   = exp_q;
        big_d   = big_q;
        sml_d   = sml_q;
        sum_d   = sum_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Input sign is ignored: operands are always non-negative.
                    opb_d   = in_data & 32'h7FFF_FFFF;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                exp_d   = acc_big ? ea : eb;
                big_d   = acc_big ? sa : sb;
                sml_d   = sh_out;
                inf_d   = ((acc_q & FP_PINF) == FP_PINF) || ((opb_q & FP_PINF) == FP_PINF);
                zero_d  = ((acc_q | opb_q) & FP_PINF) == FP_ZERO;
                state_d = ADD;
            end
            ADD: begin
                sum_d   = {1'b0, big_q} + {1'b0, sml_q};
                state_d = NORM;
            end
            NORM: begin
                if (inf_q || n_exp == EXP_INF) begin
                    acc_d = FP_PINF;
                    ovf_d = 1'b1;
                end else if (zero_q) begin
                    acc_d = FP_ZERO;
                end else begin
                    acc_d = {1'b0, n_exp, n_man};
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q + 1'b1 == CNT_W'(N_SAMPLES)) ? DONE : IDLE;
            end
            DONE: begin
                if (sum_ready) begin
                    acc_d   = FP_ZERO;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            opb_q   <= FP_ZERO;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            exp_q   <= '0;
            big_q   <= '0;
            sml_q   <= '0;
            sum_q   <= '0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            exp_q   <= exp_d;
            big_q   <= big_d;
            sml_q   <= sml_d;
            sum_q   <= sum_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign sum_valid = (state_q == DONE);
    assign sum_data  = acc_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with four samples per batch.
module tb_fp_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sum_valid;
    logic        sum_ready;
    logic [31:0] sum_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int at[4];
    int done_at;
    int t;

    fp_accumulator #(.N_SAMPLES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_data  (sum_data),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one operand and hold it until the accepting edge has passed.
    task automatic put(input logic [31:0] v, output int acc_cyc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic wait_sum();
        int n = 0;
        in_valid = 1'b0;
        while (!sum_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("sum_valid_wait", {31'b0, sum_valid}, 32'd1);
        done_at = cyc;
    endtask

    task automatic batch(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3);
        put(v0, at[0]);
        put(v1, at[1]);
        put(v2, at[2]);
        put(v3, at[3]);
        wait_sum();
    endtask

    task automatic take();
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        check("take_in_ready", {31'b0, in_ready}, 32'd1);
        check("take_sum_valid", {31'b0, sum_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sum_ready = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("rst_sum_data", sum_data, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // 1+2+3+4 with in_valid held high; also exercises backpressure.
        batch(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        check("basic_acc1", at[1] - at[0], 32'd4);
        check("basic_acc2", at[2] - at[0], 32'd8);
        check("basic_acc3", at[3] - at[0], 32'd12);
        check("basic_done", done_at - at[0], 32'd16);
        check("basic_sum", sum_data, 32'h41200000);
        check("basic_ovf", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 32'h4F000000;
            @(posedge clk); #1;
            check("bp_valid", {31'b0, sum_valid}, 32'd1);
            check("bp_data", sum_data, 32'h41200000);
            check("bp_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        take();

        batch(32'h0, 32'h0, 32'h0, 32'h0);
        check("zeros_sum", sum_data, 32'h0);
        take();

        batch(32'h0, 32'h00000001, 32'h3F800000, 32'h0);
        check("flush_sum", sum_data, 32'h3F800000);
        take();

        batch(32'h3FC00000, 32'h3FC00000, 32'h0, 32'h0);
        check("carry_sum", sum_data, 32'h40400000);
        take();

        batch(32'h4B800000, 32'h3F800000, 32'h0, 32'h0);
        check("trunc_sum", sum_data, 32'h4B800000);
        take();

        batch(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0);
        check("ovf_sum", sum_data, 32'h7F800000);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        take();
        check("ovf_cleared_early", {31'b0, overflow}, 32'd0);

        batch(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        check("post_ovf_sum", sum_data, 32'h40800000);
        check("post_ovf_flag", {31'b0, overflow}, 32'd0);
        take();

        // Reset asserted while the second operand is in ADD.
        put(32'h3F800000, t);
        put(32'h3F800000, t);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_sum_valid", {31'b0, sum_valid}, 32'd0);
        check("mid_rst_sum_data", sum_data, 32'h0);
        check("mid_rst_overflow", {31'b0, overflow}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        batch(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        check("after_rst_sum", sum_data, 32'h40800000);
        check("after_rst_done", done_at - at[0], 32'd16);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
